// File: rtl/mem_access_unit.sv
// Load/store front end for a word-wide data memory: byte/half/word requests are
// translated into word reads, word writes or read-modify-write sequences.
module mem_access_unit #(
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        STORE,
        RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic        err_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;
    logic [31:0] resp_rdata_reg;
    logic [31:0] address_reg;
    logic [31:0] write_data_reg;

    logic        accept;
    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] wdata_rep;
    logic [3:0]  lane_en;
    logic [31:0] merge_word;

    assign accept = req_valid && req_ready;

    // Rejected requests never reach the memory: bad size, misalignment, or beyond the RAM.
    assign req_err = (req_size == 2'b11)
                  || (req_size == SIZE_HALF && req_addr[0])
                  || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                  || (req_addr[31:RAM_SIZE_BIT+2] != '0);

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = reset;
                if (accept) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_write)
                        state_next = LOAD;
                    else if (req_size == SIZE_WORD)
                        state_next = STORE;
                    else
                        state_next = RMW_RD;
                end
            end
            LOAD: begin
                MemRead    = 1'b1;
                state_next = RESP;
            end
            RMW_RD: begin
                MemRead    = 1'b1;
                state_next = STORE;
            end
            STORE: begin
                MemWrite   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Load lane extraction, little-endian.
    assign load_byte = Read_data[{lane_reg, 3'b000} +: 8];
    assign load_half = Read_data[{lane_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = Read_data;
        case (size_reg)
            SIZE_BYTE: load_ext = {{24{signed_reg & load_byte[7]}}, load_byte};
            SIZE_HALF: load_ext = {{16{signed_reg & load_half[15]}}, load_half};
            default:   load_ext = Read_data;
        endcase
    end

    // Replicate store data across the word so each lane only has to choose old vs new.
    assign wdata_rep = (size_reg == SIZE_BYTE) ? {4{wdata_reg[7:0]}} : {2{wdata_reg[15:0]}};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_en[gi] = (size_reg == SIZE_BYTE) ? (lane_reg == LANE)
                                                         : (lane_reg[1] == LANE[1]);
            assign merge_word[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8]
                                                       : Read_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_reg       <= '0;
            signed_reg     <= 1'b0;
            err_reg        <= 1'b0;
            lane_reg       <= '0;
            wdata_reg      <= '0;
            resp_rdata_reg <= '0;
            address_reg    <= '0;
            write_data_reg <= '0;
        end else begin
            if (accept) begin
                size_reg    <= req_size;
                signed_reg  <= req_signed;
                err_reg     <= req_err;
                lane_reg    <= req_addr[1:0];
                wdata_reg   <= req_wdata[15:0];
                address_reg <= {req_addr[31:2], 2'b00};
                if (req_write && req_size == SIZE_WORD)
                    write_data_reg <= req_wdata;
            end
            if (state_reg == RMW_RD)
                write_data_reg <= merge_word;
            // Result register only moves as a response is presented, so it holds between responses.
            if (state_next == RESP)
                resp_rdata_reg <= (state_reg == LOAD) ? load_ext : '0;
        end
    end

    assign resp_rdata = resp_rdata_reg;
    assign Address    = address_reg;
    assign Write_data = write_data_reg;

endmodule
